comp_period_meter: RTL and testbench
====================================

Name: comp_period_meter

Overview:
- Sits directly downstream of the ADC comparator. Consumes its 1-bit sign output (1 = ADC below mid-scale).
- Glitch-filters that output, detects accepted rising edges and measures the clock-cycle period between consecutive edges.
- Delivers a period word with a valid strobe to the PLL frequency/phase loop, plus short-period and timeout status.

Parameters:
- CNT_W, 16, width of period counter and period_o.
- DEB_LEN, 4, consecutive samples required before the filtered level flips (>=1).
- MIN_PERIOD, 16, shortest period accepted; shorter edge spacing is rejected as noise.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- swiptAlive  in  1  link-alive qualifier; low acts as a synchronous clear
- comp_in  in  1  comparator output, already in clk domain
- comp_f_o  out  1  debounced comparator level
- edge_o  out  1  one-cycle pulse on each accepted rising edge
- period_o  out  CNT_W  last measured period in clk cycles
- period_valid_o  out  1  one-cycle strobe when period_o updates
- short_o  out  1  one-cycle pulse when a rising edge is rejected as too short
- timeout_o  out  1  level; no accepted edge within 2^CNT_W-1 cycles

Behaviour:
- Reset: rst=1 at a clk edge sets all outputs to 0, the debounce counter to 0, the period counter to 0 and the state to ARM. swiptAlive=0 has an identical effect, and rst has priority. Reset mid-measurement discards the partial count.
- Debounce: a counter increments each cycle comp_in != comp_f_o and clears when they are equal.
  - On the DEB_LEN-th consecutive differing sample, comp_f_o takes comp_in at that edge and the counter clears.
  - Latency from a comp_in change to comp_f_o is DEB_LEN cycles.
- Rise event: the cycle in which comp_f_o transitions 0 to 1.
- Period definition: if accepted edge_o pulses occur at cycles t0 and t1, then period = t1 - t0.
- States:
  - ARM:
    - Rise event: pulse edge_o, start counting, go to MEASURE. No period_valid_o.
  - MEASURE:
    - Counter increments every cycle.
    - Rise event with period >= MIN_PERIOD: period_o <= period, pulse period_valid_o and edge_o, restart the count.
    - Rise event with period < MIN_PERIOD: pulse short_o only. The count continues, edge_o is not pulsed and period_o holds.
    - Counter reaches 2^CNT_W-1 with no accepted edge: go to TIMEOUT, set timeout_o=1. The counter saturates and never wraps.
  - TIMEOUT:
    - timeout_o stays high.
    - Next rise event: clear timeout_o, pulse edge_o, restart the count, go to MEASURE. No period_valid_o.
- period_o holds its value between strobes. It is cleared only by rst or swiptAlive=0.
- A rise event and saturation in the same cycle: the edge wins, and it is evaluated as a normal MEASURE edge.
- All outputs are registered. period_valid_o and edge_o are asserted in the same cycle that comp_f_o becomes 1.

Decomposition:
- Shared package pll_meas_pkg holds:
  - the state enum {ARM, MEASURE, TIMEOUT};
  - the default CNT_W, DEB_LEN and MIN_PERIOD constants;
  - a function giving the saturation value 2^CNT_W-1.
- Sub-module comp_debounce (DEB_LEN): inputs clk, rst, clr, comp_in; outputs comp_f and rise.
- comp_period_meter instantiates comp_debounce and contains the FSM and period counter.

Test Plan:
1. Defaults, comp_in square wave 50 high / 50 low -> first edge: edge_o only. Every following edge: period_valid_o with period_o=100; comp_f_o lags comp_in by 4 cycles.
2. Stable low; comp_in pulses high for 2 cycles, and separately for 3 cycles -> comp_f_o never rises; no edge_o and no short_o.
3. After locking to period 100, inject a clean rising edge 10 cycles after an accepted edge (high 6, low 4) -> short_o pulses; no period_valid_o. The next true edge reports period_o=100.
4. CNT_W=8, one edge then hold low -> timeout_o rises 255 cycles after edge_o. The next edge clears timeout_o with no valid strobe. The edge after that reports its true period.
5. Mid-MEASURE, drop swiptAlive for 1 cycle -> next cycle all outputs are 0 and the state is ARM. The first edge after re-assert gives edge_o only.
6. Assert rst during TIMEOUT together with a rise event -> rst wins: outputs 0, state ARM, no edge_o.

Source files
------------

// File: rtl/pll_meas_pkg.sv
// pll_meas_pkg: shared state encoding, default parameters and saturation helper
// for the comparator period meter.
package pll_meas_pkg;
   typedef enum logic [1:0] {ARM, MEASURE, TIMEOUT} meas_state_t;
   localparam int DEF_CNT_W      = 16;
   localparam int DEF_DEB_LEN    = 4;
   localparam int DEF_MIN_PERIOD = 16;
   function automatic logic [63:0] sat_val(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction
endpackage

// File: rtl/comp_debounce.sv
// comp_debounce: filtered comparator level; rise is the combinational
// look-ahead of the 0->1 flip so downstream registers align with comp_f.
module comp_debounce
   import pll_meas_pkg::*;
#(
   parameter int DEB_LEN = DEF_DEB_LEN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic comp_in,
   output logic comp_f,
   output logic rise
);
   localparam int CW = $clog2(DEB_LEN + 1);
   logic [CW-1:0] r_cnt;
   logic          r_f;
   logic          w_diff;
   logic          w_flip;
   assign w_diff = comp_in != r_f;
   assign w_flip = w_diff && (r_cnt == CW'(DEB_LEN - 1));
   assign comp_f = r_f;
   assign rise   = w_flip && comp_in;
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
         r_f   <= 1'b0;
      end else begin
         r_f   <= w_flip ? comp_in : r_f;
         r_cnt <= (w_diff && !w_flip) ? r_cnt + CW'(1) : '0;
      end
   end
endmodule

// File: rtl/comp_period_meter.sv
// comp_period_meter: measures clock cycles between accepted rising edges of the
// debounced comparator, with short-edge rejection and timeout status.
module comp_period_meter
   import pll_meas_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int DEB_LEN    = DEF_DEB_LEN,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             swiptAlive,
   input  logic             comp_in,
   output logic             comp_f_o,
   output logic             edge_o,
   output logic [CNT_W-1:0] period_o,
   output logic             period_valid_o,
   output logic             short_o,
   output logic             timeout_o
);
   localparam logic [CNT_W-1:0] SAT   = CNT_W'(sat_val(CNT_W));
   localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
   meas_state_t      r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt, w_cnt_n, w_per_n;
   logic             w_rise, w_clr;
   logic             w_edge_n, w_valid_n, w_short_n, w_to_n;
   assign w_clr = rst || !swiptAlive;
   comp_debounce #(.DEB_LEN(DEB_LEN)) u_deb (
      .clk     (clk),
      .rst     (rst),
      .clr     (!swiptAlive),
      .comp_in (comp_in),
      .comp_f  (comp_f_o),
      .rise    (w_rise)
   );
   // r_cnt holds cycles elapsed since the last accepted edge
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_per_n   = period_o;
      w_edge_n  = 1'b0;
      w_valid_n = 1'b0;
      w_short_n = 1'b0;
      w_to_n    = timeout_o;
      case (r_state)
         ARM: if (w_rise) begin
            w_edge_n  = 1'b1;
            w_cnt_n   = CNT_W'(1);
            w_state_n = MEASURE;
         end
         MEASURE: if (w_rise && r_cnt >= MIN_P) begin
            w_edge_n  = 1'b1;
            w_valid_n = 1'b1;
            w_per_n   = r_cnt;
            w_cnt_n   = CNT_W'(1);
         end else begin
            w_short_n = w_rise;
            if (r_cnt == SAT) begin
               w_state_n = TIMEOUT;
               w_to_n    = 1'b1;
            end else
               w_cnt_n = r_cnt + CNT_W'(1);
         end
         TIMEOUT: if (w_rise) begin
            w_to_n    = 1'b0;
            w_edge_n  = 1'b1;
            w_cnt_n   = CNT_W'(1);
            w_state_n = MEASURE;
         end
         default: w_state_n = ARM;
      endcase
   end
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_state        <= ARM;
         r_cnt          <= '0;
         period_o       <= '0;
         edge_o         <= 1'b0;
         period_valid_o <= 1'b0;
         short_o        <= 1'b0;
         timeout_o      <= 1'b0;
      end else begin
         r_state        <= w_state_n;
         r_cnt          <= w_cnt_n;
         period_o       <= w_per_n;
         edge_o         <= w_edge_n;
         period_valid_o <= w_valid_n;
         short_o        <= w_short_n;
         timeout_o      <= w_to_n;
      end
   end
endmodule

// File: tb/tb_comp_period_meter.sv
// tb_comp_period_meter: directed and random stimulus on a 16-bit and an 8-bit
// meter, compared every cycle against a time-stamp based reference model.
module tb_comp_period_meter;
   import pll_meas_pkg::*;
   localparam int DEB  = 4;
   localparam int MINP = 16;
   logic clk = 1'b0;
   logic rst = 1'b1, alive = 1'b1, comp_in = 1'b0;
   logic f0, e0, v0, s0, to0;
   logic [15:0] p0;
   logic f1, e1, v1, s1, to1;
   logic [7:0] p1;
   int checks = 0, errors = 0;
   bit mf;
   bit hist[$];
   int t = 0;
   bit have[2], tmo[2], me[2], mv[2], ms[2];
   int tl[2], mp[2];
   int satv[2] = '{65535, 255};
   always #5 clk = ~clk;
   comp_period_meter dut0 (
      .clk(clk), .rst(rst), .swiptAlive(alive), .comp_in(comp_in),
      .comp_f_o(f0), .edge_o(e0), .period_o(p0), .period_valid_o(v0),
      .short_o(s0), .timeout_o(to0)
   );
   comp_period_meter #(.CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .swiptAlive(alive), .comp_in(comp_in),
      .comp_f_o(f1), .edge_o(e1), .period_o(p1), .period_valid_o(v1),
      .short_o(s1), .timeout_o(to1)
   );
   // edges are time-stamped; periods are differences of stamps
   task automatic model(input bit clr, input bit ci);
      bit rise = 1'b0;
      int ones = 0;
      t++;
      if (clr) begin
         mf = 1'b0;
         hist.delete();
      end else begin
         hist.push_back(ci);
         if (hist.size() > DEB) void'(hist.pop_front());
         foreach (hist[i]) ones += int'(hist[i]);
         if (hist.size() == DEB && ones == (mf ? 0 : DEB)) begin
            mf = !mf;
            rise = mf;
            hist.delete();
         end
      end
      for (int k = 0; k < 2; k++) begin
         me[k] = 0; mv[k] = 0; ms[k] = 0;
         if (clr) begin
            have[k] = 0; tmo[k] = 0; mp[k] = 0;
         end else if (rise && (!have[k] || tmo[k])) begin
            me[k] = 1; have[k] = 1; tmo[k] = 0; tl[k] = t;
         end else if (rise && t - tl[k] >= MINP) begin
            me[k] = 1; mv[k] = 1; mp[k] = t - tl[k]; tl[k] = t;
         end else begin
            ms[k] = rise;
            if (have[k] && !tmo[k] && t - tl[k] >= satv[k]) tmo[k] = 1;
         end
      end
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask
   task automatic cyc(input bit r, input bit a, input bit ci);
      rst = r; alive = a; comp_in = ci;
      @(posedge clk);
      model(r || !a, ci);
      #1;
      check("comp_f0", 32'(f0), 32'(mf));
      check("edge0", 32'(e0), 32'(me[0]));
      check("valid0", 32'(v0), 32'(mv[0]));
      check("short0", 32'(s0), 32'(ms[0]));
      check("timeout0", 32'(to0), 32'(tmo[0]));
      check("period0", 32'(p0), 32'(mp[0]));
      check("comp_f1", 32'(f1), 32'(mf));
      check("edge1", 32'(e1), 32'(me[1]));
      check("valid1", 32'(v1), 32'(mv[1]));
      check("short1", 32'(s1), 32'(ms[1]));
      check("timeout1", 32'(to1), 32'(tmo[1]));
      check("period1", 32'(p1), 32'(mp[1]));
   endtask
   task automatic run(input bit ci, input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, ci);
   endtask
   initial begin
      repeat (3) cyc(1, 1, 0);
      run(0, 10);
      for (int i = 0; i < 5; i++) begin run(1, 50); run(0, 50); end
      check("lock_period", 32'(p0), 32'd100);
      run(0, 20); run(1, 2); run(0, 20); run(1, 3); run(0, 20);
      for (int i = 0; i < 2; i++) begin run(1, 50); run(0, 50); end
      run(1, 6); run(0, 4); run(1, 40); run(0, 50);
      run(1, 50); run(0, 50);
      check("after_short_period", 32'(p0), 32'd100);
      run(0, 300);
      check("timeout_level", 32'(to1), 32'd1);
      for (int i = 0; i < 2; i++) begin run(1, 50); run(0, 50); end
      check("after_timeout_period", 32'(p1), 32'd100);
      run(1, 50); run(0, 20);
      cyc(0, 0, 0);
      run(0, 30);
      for (int i = 0; i < 2; i++) begin run(1, 50); run(0, 50); end
      run(0, 300);
      run(1, 3);
      cyc(1, 1, 1);
      check("rst_over_rise", 32'(e1), 32'd0);
      run(1, 20); run(0, 20);
      for (int s = 0; s < 60; s++) begin
         int n = $urandom_range(1, 120);
         bit lvl = 1'(s);
         for (int i = 0; i < n; i++) begin
            int r = $urandom_range(0, 499);
            cyc(r == 0, r != 1, ($urandom_range(0, 19) == 0) ? !lvl : lvl);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
